// File: rtl/syncfifo_sampled_ext.sv
// Synchronous FIFO with registered head-of-queue output, level flags,
// sticky error flags, high watermark and optional overwrite-oldest mode.
module syncfifo_sampled_ext #(
  parameter int WID = 32,
  parameter int DEPTH = 8,
  parameter int AWID = $clog2(DEPTH),
  parameter int OVF_MODE = 0,
  parameter logic [AWID:0] AF_LEVEL = (AWID+1)'(DEPTH-1),
  parameter logic [AWID:0] AE_LEVEL = (AWID+1)'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            softreset,
  input  logic            vldin,
  input  logic [WID-1:0]  din,
  output logic            full,
  input  logic            readout,
  output logic [WID-1:0]  dout,
  output logic            empty,
  output logic [AWID:0]   count,
  output logic            almost_full,
  output logic            almost_empty,
  output logic            overflow,
  output logic            dropped,
  output logic            underflow,
  output logic            ovf_sticky,
  output logic            udf_sticky,
  input  logic            clr_sticky,
  output logic [AWID:0]   max_count
);

  localparam logic [AWID:0]   DEPTH_C = (AWID+1)'(DEPTH);
  localparam logic [AWID:0]   CNT_ONE = (AWID+1)'(1);
  localparam logic [AWID-1:0] LAST    = AWID'(DEPTH-1);
  localparam logic            OVW     = (OVF_MODE == 1);

  logic [WID-1:0]  mem [DEPTH];
  logic [AWID-1:0] wptr;
  logic [AWID-1:0] rptr;
  logic [AWID-1:0] next_rptr;
  logic [AWID:0]   next_count;
  logic            pop;
  logic            wr;
  logic            drop;
  logic            head_new;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AWID-1:0] ptr_inc(
    input logic [AWID-1:0] p
  );
    return (p == LAST) ? '0 : p + AWID'(1);
  endfunction

  assign full      = (count == DEPTH_C);
  assign pop       = readout && !empty;
  assign wr        = vldin && (!full || pop || OVW);
  assign drop      = vldin && full && !pop && OVW;
  assign overflow  = vldin && full && !pop && !OVW;
  assign dropped   = drop;
  assign underflow = readout && empty;

  assign next_rptr = (pop || drop) ? ptr_inc(rptr) : rptr;

  // The incoming word becomes the head when the queue is (about to be) empty.
  assign head_new = (count == '0) ||
                    ((count == CNT_ONE) && pop);

  always_comb begin
    next_count = count;
    unique case (1'b1)
      (wr && !pop && !drop): next_count = count + CNT_ONE;
      (pop && !wr):          next_count = count - CNT_ONE;
      default:               next_count = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr && !softreset) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!softreset) begin
      if (head_new) begin
        dout <= din;
      end else begin
        dout <= mem[next_rptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf_sticky   <= 1'b0;
      udf_sticky   <= 1'b0;
      max_count    <= '0;
    end else if (softreset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf_sticky   <= 1'b0;
      udf_sticky   <= 1'b0;
      max_count    <= '0;
    end else begin
      if (wr) begin
        wptr <= ptr_inc(wptr);
      end
      rptr         <= next_rptr;
      count        <= next_count;
      empty        <= (next_count == '0);
      almost_full  <= (next_count >= AF_LEVEL);
      almost_empty <= (next_count <= AE_LEVEL);
      ovf_sticky   <= overflow ||
                      (ovf_sticky && !clr_sticky);
      udf_sticky   <= underflow ||
                      (udf_sticky && !clr_sticky);
      if (clr_sticky) begin
        max_count <= next_count;
      end else if (next_count > max_count) begin
        max_count <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_syncfifo_sampled_ext.sv
// Directed bench for syncfifo_sampled_ext: DEPTH=4 reject and overwrite
// modes plus a DEPTH=5 instance exercising non-power-of-two wrap.
module tb_syncfifo_sampled_ext;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       softreset = 1'b0;
  logic       vldin = 1'b0;
  logic [7:0] din = '0;
  logic       readout = 1'b0;
  logic       clr_sticky = 1'b0;

  logic       a_full, a_empty, a_af, a_ae;
  logic       a_ovf, a_drp, a_udf, a_ovs, a_uds;
  logic [7:0] a_dout;
  logic [2:0] a_cnt, a_max;

  logic       b_full, b_empty, b_af, b_ae;
  logic       b_ovf, b_drp, b_udf, b_ovs, b_uds;
  logic [7:0] b_dout;
  logic [2:0] b_cnt, b_max;

  logic       c_full, c_empty, c_af, c_ae;
  logic       c_ovf, c_drp, c_udf, c_ovs, c_uds;
  logic [7:0] c_dout;
  logic [3:0] c_cnt, c_max;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  syncfifo_sampled_ext #(.WID(8), .DEPTH(4), .OVF_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .softreset(softreset),
    .vldin(vldin), .din(din), .full(a_full),
    .readout(readout), .dout(a_dout), .empty(a_empty),
    .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .dropped(a_drp), .underflow(a_udf),
    .ovf_sticky(a_ovs), .udf_sticky(a_uds),
    .clr_sticky(clr_sticky), .max_count(a_max)
  );

  syncfifo_sampled_ext #(.WID(8), .DEPTH(4), .OVF_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .softreset(softreset),
    .vldin(vldin), .din(din), .full(b_full),
    .readout(readout), .dout(b_dout), .empty(b_empty),
    .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .dropped(b_drp), .underflow(b_udf),
    .ovf_sticky(b_ovs), .udf_sticky(b_uds),
    .clr_sticky(clr_sticky), .max_count(b_max)
  );

  syncfifo_sampled_ext #(.WID(8), .DEPTH(5), .OVF_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .softreset(softreset),
    .vldin(vldin), .din(din), .full(c_full),
    .readout(readout), .dout(c_dout), .empty(c_empty),
    .count(c_cnt), .almost_full(c_af), .almost_empty(c_ae),
    .overflow(c_ovf), .dropped(c_drp), .underflow(c_udf),
    .ovf_sticky(c_ovs), .udf_sticky(c_uds),
    .clr_sticky(clr_sticky), .max_count(c_max)
  );

  typedef struct {
    logic       v;
    logic       r;
    logic       clr;
    logic [7:0] d;
    logic       e_ovf;
    logic       e_udf;
    logic [2:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic       e_af;
    logic       e_ae;
    logic       e_ovs;
    logic       e_uds;
    logic [7:0] e_dout;
    logic       chk_dout;
  } vec_t;

  vec_t tbl[17];
  logic [7:0] q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r,
                       input logic [7:0] d,
                       input logic clr, input logic sr);
    @(negedge clk);
    vldin = v;
    readout = r;
    din = d;
    clr_sticky = clr;
    softreset = sr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c_pop(input int k);
    drive(0, 1, 8'h00, 0, 0);
    tick();
    void'(q.pop_front());
    chk($sformatf("c drain%0d cnt", k), c_cnt, q.size());
    if (q.size() > 0)
      chk($sformatf("c drain%0d dout", k), c_dout, q[0]);
  endtask

  initial begin
    logic [7:0] a_exp[4];
    logic [7:0] b_exp[4];
    logic       pop_m;
    logic       acc_m;

    //        v r c d      ovf udf cnt e f af ae os us dout  chk
    tbl[0]  = '{1,0,0,8'h11, 0,0, 1,0,0,0,1,0,0, 8'h11,1};
    tbl[1]  = '{1,0,0,8'h22, 0,0, 2,0,0,0,0,0,0, 8'h11,1};
    tbl[2]  = '{1,0,0,8'h33, 0,0, 3,0,0,1,0,0,0, 8'h11,1};
    tbl[3]  = '{1,0,0,8'h44, 0,0, 4,0,1,1,0,0,0, 8'h11,1};
    tbl[4]  = '{1,0,0,8'h55, 1,0, 4,0,1,1,0,1,0, 8'h11,1};
    tbl[5]  = '{1,1,0,8'h66, 0,0, 4,0,1,1,0,1,0, 8'h22,1};
    tbl[6]  = '{0,1,0,8'h00, 0,0, 3,0,0,1,0,1,0, 8'h33,1};
    tbl[7]  = '{0,1,0,8'h00, 0,0, 2,0,0,0,0,1,0, 8'h44,1};
    tbl[8]  = '{0,1,0,8'h00, 0,0, 1,0,0,0,1,1,0, 8'h66,1};
    tbl[9]  = '{0,1,0,8'h00, 0,0, 0,1,0,0,1,1,0, 8'h00,0};
    tbl[10] = '{0,1,0,8'h00, 0,1, 0,1,0,0,1,1,1, 8'h00,0};
    tbl[11] = '{0,0,1,8'h00, 0,0, 0,1,0,0,1,0,0, 8'h00,0};
    tbl[12] = '{1,0,0,8'hA5, 0,0, 1,0,0,0,1,0,0, 8'hA5,1};
    tbl[13] = '{1,1,0,8'h5A, 0,0, 1,0,0,0,1,0,0, 8'h5A,1};
    tbl[14] = '{0,1,0,8'h00, 0,0, 0,1,0,0,1,0,0, 8'h00,0};
    tbl[15] = '{0,1,1,8'h00, 0,1, 0,1,0,0,1,0,1, 8'h00,0};
    tbl[16] = '{0,0,1,8'h00, 0,0, 0,1,0,0,1,0,0, 8'h00,0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst cnt", a_cnt, 0);
    chk("rst empty", a_empty, 1);
    chk("rst ae", a_ae, 1);
    chk("rst af", a_af, 0);
    chk("rst full", a_full, 0);
    chk("rst dout", a_dout, 0);
    chk("rst ovs", a_ovs, 0);
    chk("rst uds", a_uds, 0);
    chk("rst max", a_max, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].clr, 0);
      chk($sformatf("v%0d ovf", i), a_ovf, tbl[i].e_ovf);
      chk($sformatf("v%0d udf", i), a_udf, tbl[i].e_udf);
      tick();
      chk($sformatf("v%0d cnt", i), a_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d empty", i), a_empty, tbl[i].e_empty);
      chk($sformatf("v%0d full", i), a_full, tbl[i].e_full);
      chk($sformatf("v%0d af", i), a_af, tbl[i].e_af);
      chk($sformatf("v%0d ae", i), a_ae, tbl[i].e_ae);
      chk($sformatf("v%0d ovs", i), a_ovs, tbl[i].e_ovs);
      chk($sformatf("v%0d uds", i), a_uds, tbl[i].e_uds);
      if (tbl[i].chk_dout)
        chk($sformatf("v%0d dout", i), a_dout, tbl[i].e_dout);
    end

    // Reject vs overwrite-oldest on the same full queue.
    drive(0, 0, 8'h00, 0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h11 * (i + 1), 0, 0);
      tick();
    end
    drive(1, 0, 8'h55, 0, 0);
    chk("m ovf a", a_ovf, 1);
    chk("m drp a", a_drp, 0);
    chk("m ovf b", b_ovf, 0);
    chk("m drp b", b_drp, 1);
    tick();
    chk("m cnt b", b_cnt, 4);
    chk("m ovs a", a_ovs, 1);
    chk("m ovs b", b_ovs, 0);
    a_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_exp = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m a head%0d", k), a_dout, a_exp[k]);
      chk($sformatf("m b head%0d", k), b_dout, b_exp[k]);
      drive(0, 1, 8'h00, 0, 0);
      tick();
    end
    chk("m a empty", a_empty, 1);
    chk("m b empty", b_empty, 1);

    // DEPTH=5 wrap with interleaved traffic against a queue model.
    drive(0, 0, 8'h00, 0, 1);
    tick();
    q.delete();
    for (int i = 0; i < 12; i++) begin
      drive(1, (i % 2) == 1, 8'h30 + 8'(i), 0, 0);
      pop_m = ((i % 2) == 1) && (q.size() > 0);
      acc_m = (q.size() < 5) || pop_m;
      chk($sformatf("c w%0d ovf", i), c_ovf, !acc_m);
      tick();
      if (pop_m) void'(q.pop_front());
      if (acc_m) q.push_back(8'h30 + 8'(i));
      chk($sformatf("c w%0d cnt", i), c_cnt, q.size());
      chk($sformatf("c w%0d dout", i), c_dout, q[0]);
    end
    chk("c max", c_max, 5);
    c_pop(0);
    c_pop(1);
    drive(0, 0, 8'h00, 1, 0);
    tick();
    chk("c max clr", c_max, q.size());
    for (int k = 2; k < 12 && q.size() > 0; k++) c_pop(k);
    chk("c empty", c_empty, 1);

    // Synchronous clear with a discarded write in the same cycle.
    drive(0, 1, 8'h00, 0, 0);
    tick();
    chk("s uds", a_uds, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'hD0 + 8'(i), 0, 0);
      tick();
    end
    chk("s pre cnt", a_cnt, 3);
    drive(1, 0, 8'hEE, 0, 1);
    tick();
    chk("s cnt", a_cnt, 0);
    chk("s empty", a_empty, 1);
    chk("s ae", a_ae, 1);
    chk("s af", a_af, 0);
    chk("s uds clr", a_uds, 0);
    chk("s max", a_max, 0);
    drive(1, 0, 8'h77, 0, 0);
    tick();
    chk("s new dout", a_dout, 8'h77);
    chk("s new cnt", a_cnt, 1);

    // Asynchronous reset mid-cycle with traffic pending.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h78 + 8'(i), 0, 0);
      tick();
    end
    chk("r ovs set", a_ovs, 1);
    @(negedge clk);
    vldin = 1'b1;
    din = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    chk("r cnt", a_cnt, 0);
    chk("r empty", a_empty, 1);
    chk("r ae", a_ae, 1);
    chk("r full", a_full, 0);
    chk("r dout", a_dout, 0);
    chk("r ovs", a_ovs, 0);
    chk("r max", a_max, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vldin = 1'b0;
    drive(1, 0, 8'hC3, 0, 0);
    tick();
    chk("r new dout", a_dout, 8'hC3);
    chk("r new cnt", a_cnt, 1);

    drive(0, 0, 8'h00, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/syncfifo_sampled_ext.md
# syncfifo_sampled_ext

Parametrised synchronous FIFO with a registered ("sampled") head-of-queue output, for buffering AXI NoC channel payloads between a producer and a registered consumer. It extends the basic sampled FIFO with: non-power-of-two depth, write acceptance while full if a pop happens in the same cycle, a selectable overwrite-oldest mode, registered almost-full/almost-empty levels, sticky error flags and a high-watermark counter.

## Interface
- WID, 32: payload width.
- DEPTH, 8: number of entries; any integer >= 2.
- AWID, $clog2(DEPTH): pointer width. count, max_count and the level parameters are AWID+1 bits.
- OVF_MODE, 0: 0 = reject a write when full; 1 = overwrite the oldest entry when full.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- softreset  in  1  synchronous clear of all state. Memory contents are not cleared.
- vldin  in  1  write request.
- din  in  WID  write data.
- full  out  1  combinational: count == DEPTH.
- readout  in  1  pop request. Ignored when empty.
- dout  out  WID  registered: oldest entry, valid whenever empty == 0.
- empty  out  1  registered; reset 1.
- count  out  AWID+1  registered occupancy; reset 0.
- almost_full  out  1  registered; reset 0.
- almost_empty  out  1  registered; reset 1.
- overflow  out  1  combinational pulse: a write was rejected (OVF_MODE 0 only).
- dropped  out  1  combinational pulse: the oldest entry was overwritten (OVF_MODE 1 only).
- underflow  out  1  combinational pulse: readout && empty.
- ovf_sticky, udf_sticky  out  1  registered sticky flags; reset 0.
- clr_sticky  in  1  clears ovf_sticky, udf_sticky and max_count.
- max_count  out  AWID+1  registered high watermark of count; reset 0.

## Operation
- pop = readout && !empty.
- wr = vldin && (!full || pop || OVF_MODE==1).
- drop = vldin && full && !pop && OVF_MODE==1.
- overflow = vldin && full && !pop && OVF_MODE==0.
- Pointer wptr advances on wr. Pointer rptr advances on pop or on drop.
- Both pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- next_count is:
  - count+1 on wr without pop and without drop;
  - count-1 on pop without wr;
  - count otherwise.
- count, empty, almost_full and almost_empty are all registered from next_count.
- dout update, each cycle:
  - If the new head is the entry being written this cycle, dout <= din. This happens when count==0, or count==1 with pop.
  - Otherwise dout <= mem[next_rptr], read from memory before the write. During drop, next_rptr = rptr+1, which is never the slot being written.
  - When next_count==0, dout still loads din; its value is a don't-care.
- Memory write: mem[wptr] <= din on wr.
- Sticky flags:
  - ovf_sticky sets on overflow, udf_sticky sets on underflow.
  - dropped does not set ovf_sticky.
  - If clr_sticky and a set event occur in the same cycle, the set wins.
- max_count <= max(max_count, next_count). On clr_sticky, max_count <= next_count.
- softreset: pointers, count, max_count and flags go to their reset values; empty=1, almost_empty=1. Requests in that cycle are discarded.
- rst_n low at any time: same as softreset, immediately (asynchronous). dout resets to 0.

## Timing
- Write-to-visible latency is 1 cycle. A write into an empty FIFO at edge N gives empty=0 and dout=din after edge N; a pop is possible in the next cycle.
- After a pop at edge N, dout shows the next entry after edge N. Back-to-back pops drain one entry per cycle.
- Full throughput: simultaneous write and pop every cycle at any occupancy, including full, with count unchanged.
- full is combinational from registered count, so it has no latency beyond count.
- The pulse outputs (overflow, dropped, underflow) are combinational in the request cycle. The sticky flags and max_count follow one edge later.

## Test plan
- DEPTH=4, WID=8, mode 0: write 0x11, 0x22, 0x33, 0x44 with no reads -> full=1, count=4, dout=0x11, almost_full=1 after the third write. A fifth write of 0x55 -> overflow pulse, ovf_sticky=1, contents unchanged.
- Full FIFO, vldin and readout together with din=0x66 -> count stays 4, dout=0x22 next cycle, overflow=0. Draining then yields 0x22, 0x33, 0x44, 0x66.
- Mode 1, full with 0x11..0x44, write 0x55 without a read -> dropped pulse, count=4, dout=0x22. Draining yields 0x22, 0x33, 0x44, 0x55.
- Empty FIFO, write 0xA5, then in the next cycle pop and write 0x5A together -> dout=0x5A after that edge, count=1. Pop on an empty FIFO -> underflow pulse, udf_sticky=1; clr_sticky clears it.
- DEPTH=5 (non-power-of-two): 12 writes and reads interleaved, 2 writes per 1 read, then drain -> data order preserved across pointer wrap; max_count=5, then clr_sticky -> max_count = current count.
- FIFO holding 3 entries: assert softreset, then separately rst_n mid-traffic -> count=0, empty=1, almost_empty=1, flags=0. The next write returns the new data only.
